sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//
// Arbitrates one SDRAM controller command port between three requesters
// (0 = CPU, 1 = camera DMA, 2 = display DMA). Requester 2 has strict
// priority; requesters 0 and 1 share the port round-robin. The winner's
// command is latched at grant time and held until the controller accepts
// it, then the arbiter waits for burst completion and pulses doneVec.
//
// Optional feature (macro STARVATION_GUARD_EN): saturating wait counters for
// requesters 0 and 1; a counter at or above MAX_WAIT lifts that requester
// above requester 2.
//
// Ports
//   systemClock            : clock, rising edge
//   nReset                 : synchronous active-low reset
//   reqVec[2:0]            : request per requester
//   addrVec                : start word address per requester (slice i)
//   rnwVec[2:0]            : 1 = read, 0 = write, per requester
//   burstVec               : burst length minus 1 per requester (slice i)
//   grantVec[2:0]          : one-hot current owner of the SDRAM port
//   doneVec[2:0]           : one-cycle completion pulse to the owner
//   memReq/memRnw/memAddr/memBurstLen : registered command to the controller
//   memAck                 : controller accepted the command
//   memDone                : controller finished the burst
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned BURST_WIDTH = 8,
    parameter int unsigned MAX_WAIT    = 64
) (
    input  logic                       systemClock,
    input  logic                       nReset,
    input  logic [2:0]                 reqVec,
    input  logic [3*ADDR_WIDTH-1:0]    addrVec,
    input  logic [2:0]                 rnwVec,
    input  logic [3*BURST_WIDTH-1:0]   burstVec,
    output logic [2:0]                 grantVec,
    output logic [2:0]                 doneVec,
    output logic                       memReq,
    output logic                       memRnw,
    output logic [ADDR_WIDTH-1:0]      memAddr,
    output logic [BURST_WIDTH-1:0]     memBurstLen,
    input  logic                       memAck,
    input  logic                       memDone
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // The starvation limit must be a real, nonzero number of cycles.
    if (MAX_WAIT == 0) begin : g_max_wait_check
        $error("sdram_port_arbiter: MAX_WAIT must be at least 1");
    end

    state_t                  state_q, state_d;
    logic [2:0]              grant_q, grant_d;
    logic [2:0]              done_q, done_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_rnw_q, mem_rnw_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [BURST_WIDTH-1:0]  mem_burst_q, mem_burst_d;
    logic                    rr_q, rr_d;       // 0: requester 0 favoured, 1: requester 1 favoured

    logic [2:0]              win_c;            // one-hot arbitration result
    logic [1:0]              expired_c;        // requester 0/1 has waited too long
    logic [ADDR_WIDTH-1:0]   sel_addr_c;
    logic                    sel_rnw_c;
    logic [BURST_WIDTH-1:0]  sel_burst_c;

`ifdef STARVATION_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [1:0][WAIT_W-1:0]  wait_q, wait_d;

    // Expiry only matters while the requester is still asking.
    always_comb begin
        expired_c = 2'b00;
        for (int i = 0; i < 2; i++) begin
            expired_c[i] = reqVec[i] && (wait_q[i] >= WAIT_W'(MAX_WAIT));
        end
    end

    // Saturating wait counters: count while requesting and not owning, clear on grant.
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < 2; i++) begin
            if (grant_d[i]) begin
                wait_d[i] = '0;
            end else if (reqVec[i] && !grant_q[i] && (wait_q[i] < WAIT_W'(MAX_WAIT))) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge systemClock) begin
        if (!nReset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign expired_c = 2'b00;
`endif

    // Winner selection: expired low-priority requesters, then 2, then round-robin 0/1.
    always_comb begin
        win_c = 3'b000;
        if (expired_c[0] && expired_c[1]) begin
            win_c = rr_q ? 3'b010 : 3'b001;
        end else if (expired_c[0]) begin
            win_c = 3'b001;
        end else if (expired_c[1]) begin
            win_c = 3'b010;
        end else if (reqVec[2]) begin
            win_c = 3'b100;
        end else if (reqVec[0] && reqVec[1]) begin
            win_c = rr_q ? 3'b010 : 3'b001;
        end else if (reqVec[0]) begin
            win_c = 3'b001;
        end else if (reqVec[1]) begin
            win_c = 3'b010;
        end
    end

    // Command fields of the winner.
    always_comb begin
        sel_addr_c  = addrVec[0 +: ADDR_WIDTH];
        sel_rnw_c   = rnwVec[0];
        sel_burst_c = burstVec[0 +: BURST_WIDTH];
        if (win_c[2]) begin
            sel_addr_c  = addrVec[2*ADDR_WIDTH +: ADDR_WIDTH];
            sel_rnw_c   = rnwVec[2];
            sel_burst_c = burstVec[2*BURST_WIDTH +: BURST_WIDTH];
        end else if (win_c[1]) begin
            sel_addr_c  = addrVec[ADDR_WIDTH +: ADDR_WIDTH];
            sel_rnw_c   = rnwVec[1];
            sel_burst_c = burstVec[BURST_WIDTH +: BURST_WIDTH];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = 3'b000;
        mem_req_d   = mem_req_q;
        mem_rnw_d   = mem_rnw_q;
        mem_addr_d  = mem_addr_q;
        mem_burst_d = mem_burst_q;
        rr_d        = rr_q;

        unique case (state_q)
            IDLE: begin
                // memDone and memAck are ignored here.
                if (win_c != 3'b000) begin
                    state_d     = ISSUE;
                    grant_d     = win_c;
                    mem_req_d   = 1'b1;
                    mem_rnw_d   = sel_rnw_c;
                    mem_addr_d  = sel_addr_c;
                    mem_burst_d = sel_burst_c;
                    // Pointer moves to the other low-priority requester only when one of them wins.
                    if (win_c[0]) begin
                        rr_d = 1'b1;
                    end else if (win_c[1]) begin
                        rr_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    // Ack and completion in the same cycle finish the transfer outright.
                    if (memDone) begin
                        done_d  = grant_q;
                        grant_d = 3'b000;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (memDone) begin
                    done_d  = grant_q;
                    grant_d = 3'b000;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = 3'b000;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge systemClock) begin
        if (!nReset) begin
            state_q     <= IDLE;
            grant_q     <= 3'b000;
            done_q      <= 3'b000;
            mem_req_q   <= 1'b0;
            mem_rnw_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_burst_q <= '0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_addr_q  <= mem_addr_d;
            mem_burst_q <= mem_burst_d;
            rr_q        <= rr_d;
        end
    end

    assign grantVec    = grant_q;
    assign doneVec     = done_q;
    assign memReq      = mem_req_q;
    assign memRnw      = mem_rnw_q;
    assign memAddr     = mem_addr_q;
    assign memBurstLen = mem_burst_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared with a transaction-level reference model that tracks
// the current owner, whether its command is still outstanding, and the
// arbitration rules (display first, CPU/camera alternate, optional
// starvation limit when STARVATION_GUARD_EN is defined).
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

    localparam int unsigned AW   = 24;
    localparam int unsigned BW   = 8;
    localparam int unsigned MAXW = 4;

    logic            clk;
    logic            nrst;
    logic [2:0]      req;
    logic [3*AW-1:0] addr;
    logic [2:0]      rnw;
    logic [3*BW-1:0] burst;
    logic            ack;
    logic            done;
    logic [2:0]      grant_vec;
    logic [2:0]      done_vec;
    logic            mem_req;
    logic            mem_rnw;
    logic [AW-1:0]   mem_addr;
    logic [BW-1:0]   mem_burst;

    int checks   = 0;
    int failures = 0;
    string tag = "reset";

    // Reference model state
    int            m_owner;     // -1 when nobody owns the port
    bit            m_pending;   // command not yet accepted by the controller
    logic [2:0]    m_done;
    int            m_fav;       // which of 0/1 wins a tie next
    int            m_w[2];
    logic          m_rnw;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_burst;

    sdram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .BURST_WIDTH(BW),
        .MAX_WAIT   (MAXW)
    ) dut (
        .systemClock(clk),
        .nReset     (nrst),
        .reqVec     (req),
        .addrVec    (addr),
        .rnwVec     (rnw),
        .burstVec   (burst),
        .grantVec   (grant_vec),
        .doneVec    (done_vec),
        .memReq     (mem_req),
        .memRnw     (mem_rnw),
        .memAddr    (mem_addr),
        .memBurstLen(mem_burst),
        .memAck     (ack),
        .memDone    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
        bit e0;
        bit e1;
        e0 = 1'b0;
        e1 = 1'b0;
`ifdef STARVATION_GUARD_EN
        e0 = r[0] && (m_w[0] >= int'(MAXW));
        e1 = r[1] && (m_w[1] >= int'(MAXW));
`endif
        if (e0 && e1) return m_fav;
        if (e0) return 0;
        if (e1) return 1;
        if (r[2]) return 2;
        if (r[0] && r[1]) return m_fav;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    task automatic model_update();
        int old_owner;
        int p;
        if (!nrst) begin
            m_owner   = -1;
            m_pending = 1'b0;
            m_done    = 3'b000;
            m_fav     = 0;
            m_w[0]    = 0;
            m_w[1]    = 0;
            m_rnw     = 1'b1;
            m_addr    = '0;
            m_burst   = '0;
            return;
        end
        m_done    = 3'b000;
        old_owner = m_owner;
        if (m_owner < 0) begin
            p = pick(req);
            if (p >= 0) begin
                m_owner   = p;
                m_pending = 1'b1;
                m_addr    = addr[p*AW +: AW];
                m_rnw     = rnw[p];
                m_burst   = burst[p*BW +: BW];
                if (p < 2) m_fav = 1 - p;
            end
        end else if (m_pending) begin
            if (ack) begin
                m_pending = 1'b0;
                if (done) begin
                    m_done  = 3'(1 << m_owner);
                    m_owner = -1;
                end
            end
        end else if (done) begin
            m_done  = 3'(1 << m_owner);
            m_owner = -1;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_owner == i && old_owner < 0) m_w[i] = 0;
            else if (req[i] && old_owner != i && m_w[i] < int'(MAXW)) m_w[i]++;
        end
    endtask

    // Advance one clock with the current inputs and compare every output.
    task automatic step();
        logic [2:0] exp_grant;
        model_update();
        @(posedge clk);
        #1;
        exp_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        chk({tag, "_grant"},  32'(grant_vec), 32'(exp_grant));
        chk({tag, "_done"},   32'(done_vec),  32'(m_done));
        chk({tag, "_memreq"}, 32'(mem_req),   32'(m_pending));
        chk({tag, "_memrnw"}, 32'(mem_rnw),   32'(m_rnw));
        chk({tag, "_addr"},   32'(mem_addr),  32'(m_addr));
        chk({tag, "_burst"},  32'(mem_burst), 32'(m_burst));
        chk({tag, "_onehot"}, 32'($countones(grant_vec) <= 1), 32'd1);
    endtask

    function automatic int grant_idx(input logic [2:0] g);
        if (g == 3'b001) return 0;
        if (g == 3'b010) return 1;
        if (g == 3'b100) return 2;
        return -1;
    endfunction

    initial begin
        int order[$];
        int bad;
        int first0;
        nrst  = 1'b0;
        req   = 3'b000;
        addr  = '0;
        rnw   = 3'b111;
        burst = '0;
        ack   = 1'b0;
        done  = 1'b0;

        // Reset values
        tag = "reset";
        step();
        step();
        chk("reset_grant", 32'(grant_vec), 32'd0);
        chk("reset_rnw",   32'(mem_rnw),   32'd1);
        chk("reset_req",   32'(mem_req),   32'd0);

        // Single CPU request: ack sampled in cycle 3, done sampled in cycle 12
        tag  = "single";
        nrst = 1'b1;
        req  = 3'b001;
        addr = {24'h0, 24'h0, 24'h000100};
        burst = {8'd0, 8'd0, 8'd7};
        rnw  = 3'b001;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step();
            chk("single_grant_t",  32'(grant_vec), (cyc <= 12) ? 32'd1 : 32'd0);
            chk("single_memreq_t", 32'(mem_req),   32'(cyc <= 3));
            chk("single_done_t",   32'(done_vec),  (cyc == 13) ? 32'd1 : 32'd0);
            if (cyc == 1) begin
                chk("single_addr_t",  32'(mem_addr),  32'h000100);
                chk("single_burst_t", 32'(mem_burst), 32'd7);
                req = 3'b000;
            end
            ack  = (cyc == 3);
            done = (cyc == 12);
        end

        // All three requesting with instant ack/done
        tag  = "prio";
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        req  = 3'b111;
        ack  = 1'b1;
        done = 1'b1;
        bad  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (grant_vec != 3'b000 && grant_vec != 3'b100) bad++;
        end
`ifndef STARVATION_GUARD_EN
        chk("prio_only2", 32'(bad), 32'd0);
`endif
        tag = "rr";
        req = 3'b011;
        for (int i = 0; i < 16; i++) begin
            step();
            if (grant_vec != 3'b000) order.push_back(grant_idx(grant_vec));
        end
`ifndef STARVATION_GUARD_EN
        chk("rr_count", 32'(order.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", (order.size() > i) ? 32'(order[i]) : 32'hFF, 32'(i % 2));
        end
`endif

        // Early drop of the request after the grant
        tag  = "drop";
        nrst = 1'b0;
        ack  = 1'b0;
        done = 1'b0;
        step();
        nrst  = 1'b1;
        req   = 3'b001;
        addr  = {24'h111111, 24'h222222, 24'h0ABCDE};
        rnw   = 3'b110;
        burst = {8'd1, 8'd2, 8'd3};
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            chk("drop_memreq_t", 32'(mem_req),  32'(cyc <= 2));
            chk("drop_done_t",   32'(done_vec), (cyc == 5) ? 32'd1 : 32'd0);
            if (cyc <= 4) chk("drop_addr_t", 32'(mem_addr), 32'h0ABCDE);
            if (cyc == 1) begin
                req  = 3'b000;
                addr = {24'h333333, 24'h444444, 24'h555555};
                rnw  = 3'b111;
            end
            ack  = (cyc == 2);
            done = (cyc == 4);
        end

        // Reset while waiting for completion
        tag  = "rst_mid";
        req  = 3'b010;
        ack  = 1'b0;
        done = 1'b0;
        step();
        req = 3'b000;
        ack = 1'b1;
        step();
        ack  = 1'b0;
        nrst = 1'b0;
        step();
        chk("rst_mid_grant", 32'(grant_vec), 32'd0);
        chk("rst_mid_done",  32'(done_vec),  32'd0);
        chk("rst_mid_req",   32'(mem_req),   32'd0);
        chk("rst_mid_addr",  32'(mem_addr),  32'd0);
        nrst = 1'b1;
        done = 1'b1;
        step();
        chk("idle_done_ignored", 32'(done_vec), 32'd0);
        done = 1'b0;
        step();

        // Continuous display traffic against a waiting CPU
        tag  = "starve";
        nrst = 1'b0;
        step();
        nrst   = 1'b1;
        req    = 3'b101;
        ack    = 1'b1;
        done   = 1'b1;
        first0 = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (grant_vec == 3'b001 && first0 < 0) first0 = cyc;
        end
`ifdef STARVATION_GUARD_EN
        chk("starve_on_bound", 32'(first0 > 0 && first0 <= int'(MAXW) + 2), 32'd1);
`else
        chk("starve_off_never", 32'(first0), 32'hFFFFFFFF);
`endif

        // Randomized traffic
        tag = "rand";
        for (int i = 0; i < 1500; i++) begin
            nrst  = ($urandom_range(0, 99) != 0);
            req   = 3'($urandom);
            addr  = {8'($urandom), 32'($urandom), 32'($urandom)};
            rnw   = 3'($urandom);
            burst = 24'($urandom);
            ack   = ($urandom_range(0, 1) == 1);
            done  = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
